// File: rtl/scoreboard_entry_ctrl_if.sv
// Insert-side bundle for scoreboard_entry_ctrl: game/button inputs and scoreboard insert outputs.
// slave is the controller's view; master is the driver/consumer side.
interface scoreboard_entry_ctrl_if #(
    parameter int LETTER_W = 5,
    parameter int KEY_W    = 16
);
    logic                  game_over;
    logic [KEY_W-1:0]      final_score;
    logic [KEY_W-1:0]      min_score;
    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_confirm;
    logic                  btn_back;
    logic                  insert;
    logic [KEY_W-1:0]      key_insert;
    logic [3*LETTER_W-1:0] string_insert;
    logic [1:0]            cursor;
    logic                  busy;
    logic                  done;
    logic                  qualified;

    modport slave (
        input  game_over, final_score, min_score,
        input  btn_up, btn_down, btn_confirm, btn_back,
        output insert, key_insert, string_insert, cursor, busy, done, qualified
    );

    modport master (
        output game_over, final_score, min_score,
        output btn_up, btn_down, btn_confirm, btn_back,
        input  insert, key_insert, string_insert, cursor, busy, done, qualified
    );
endinterface

// File: rtl/scoreboard_entry_ctrl.sv
// High-score entry sequencer: qualify score, three-letter name entry, single insert strobe, settle.
// Optional idle auto-commit in ENTRY is built only when ENTRY_TIMEOUT_EN is defined.
module scoreboard_entry_ctrl #(
    parameter int LETTER_W       = 5,
    parameter int KEY_W          = 16,
    parameter int LETTER_MAX     = 25,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    scoreboard_entry_ctrl_if.slave   bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUALIFY,
        S_ENTRY,
        S_COMMIT,
        S_SETTLE
    } state_e;

    state_e                state_q, state_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic [LETTER_W-1:0]   letter_q [3];
    logic [LETTER_W-1:0]   letter_d [3];
    logic [1:0]            cursor_q, cursor_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic                  qualifies;
    logic                  settle_last;

    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    assign qualifies   = key_q > bus.min_score;
    assign settle_last = settle_q == SW'(SETTLE_CYCLES - 1);

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
    logic          any_btn;
    logic          timed_out;

    assign any_btn   = bus.btn_up | bus.btn_down | bus.btn_confirm | bus.btn_back;
    assign timed_out = !any_btn && (to_q == TW'(TIMEOUT_CYCLES - 1));

    // Counter only advances in ENTRY and restarts on any button or outside ENTRY.
    always_comb begin
        to_d = '0;
        if (state_q == S_ENTRY && !any_btn)
            to_d = to_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_q <= '0;
        else     to_q <= to_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.game_over) state_d = S_QUALIFY;
            S_QUALIFY: state_d = qualifies ? S_ENTRY : S_IDLE;
            S_ENTRY: begin
                if (bus.btn_confirm && cursor_q == 2'd2)
                    state_d = S_COMMIT;
`ifdef ENTRY_TIMEOUT_EN
                else if (timed_out)
                    state_d = S_COMMIT;
`endif
            end
            S_COMMIT:  state_d = S_SETTLE;
            S_SETTLE:  if (settle_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = state_q != S_IDLE;
        bus.insert    = state_q == S_COMMIT;
        bus.qualified = (state_q == S_SETTLE) && settle_last;
        bus.done      = ((state_q == S_QUALIFY) && !qualifies) ||
                        ((state_q == S_SETTLE) && settle_last);
    end

    // Datapath: only the highest-priority button (confirm > back > up > down) acts.
    always_comb begin
        key_d    = key_q;
        letter_d = letter_q;
        cursor_d = cursor_q;
        settle_d = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.game_over) begin
                    key_d    = bus.final_score;
                    cursor_d = '0;
                    for (int unsigned i = 0; i < 3; i++) letter_d[i] = '0;
                end
            end
            S_ENTRY: begin
                if (bus.btn_confirm) begin
                    if (cursor_q != 2'd2) cursor_d = cursor_q + 2'd1;
                end else if (bus.btn_back) begin
                    if (cursor_q != 2'd0) cursor_d = cursor_q - 2'd1;
                end else if (bus.btn_up || bus.btn_down) begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (cursor_q == 2'(i)) begin
                            if (bus.btn_up)
                                letter_d[i] = (letter_q[i] == LETTER_W'(LETTER_MAX)) ?
                                              '0 : letter_q[i] + LETTER_W'(1);
                            else
                                letter_d[i] = (letter_q[i] == '0) ?
                                              LETTER_W'(LETTER_MAX) : letter_q[i] - LETTER_W'(1);
                        end
                    end
                end
            end
            S_SETTLE: settle_d = settle_q + SW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q    <= '0;
            cursor_q <= '0;
            settle_q <= '0;
            for (int unsigned i = 0; i < 3; i++) letter_q[i] <= '0;
        end else begin
            key_q    <= key_d;
            cursor_q <= cursor_d;
            settle_q <= settle_d;
            for (int unsigned i = 0; i < 3; i++) letter_q[i] <= letter_d[i];
        end
    end

    assign bus.key_insert    = key_q;
    assign bus.string_insert = {letter_q[0], letter_q[1], letter_q[2]};
    assign bus.cursor        = cursor_q;

endmodule

// File: tb/tb_scoreboard_entry_ctrl.sv
// Directed bench for scoreboard_entry_ctrl: table-driven name entry plus reject/reset/timeout sequences.
module tb_scoreboard_entry_ctrl;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ins_cnt = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    scoreboard_entry_ctrl_if #(.LETTER_W(5), .KEY_W(16)) bus ();

    scoreboard_entry_ctrl #(
        .LETTER_W      (5),
        .KEY_W         (16),
        .LETTER_MAX    (25),
        .SETTLE_CYCLES (SETTLE),
`ifdef ENTRY_TIMEOUT_EN
        .TIMEOUT_CYCLES(16)
`else
        .TIMEOUT_CYCLES(100_000_000)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.insert) ins_cnt++;
        if (bus.done)   done_cnt++;
    end

    typedef struct {
        logic        up, down, confirm, back, gover;
        logic [1:0]  exp_cur;
        logic [14:0] exp_str;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [14:0] mk(input int a, input int b, input int c);
        return {a[4:0], b[4:0], c[4:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic btns(input logic u, input logic d, input logic c, input logic b);
        bus.btn_up = u; bus.btn_down = d; bus.btn_confirm = c; bus.btn_back = b;
    endtask

    task automatic start(input int score, input int mins);
        bus.game_over   = 1'b1;
        bus.final_score = 16'(score);
        bus.min_score   = 16'(mins);
        step();
        bus.game_over   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(bus.busy), 0);
        chk({tag, "_insert"}, 32'(bus.insert), 0);
        chk({tag, "_done"},   32'(bus.done), 0);
        chk({tag, "_qual"},   32'(bus.qualified), 0);
        chk({tag, "_cursor"}, 32'(bus.cursor), 0);
        chk({tag, "_key"},    32'(bus.key_insert), 0);
        chk({tag, "_str"},    32'(bus.string_insert), 0);
    endtask

    initial begin
        vecs[0] = '{0,0,0,1,0, 2'd0, mk(0,0,0)};   // back at cursor 0 ignored
        vecs[1] = '{1,0,0,0,0, 2'd0, mk(1,0,0)};
        vecs[2] = '{1,1,0,0,0, 2'd0, mk(2,0,0)};   // up beats down
        vecs[3] = '{0,0,0,0,1, 2'd0, mk(2,0,0)};   // game_over ignored in ENTRY
        vecs[4] = '{0,0,1,0,0, 2'd1, mk(2,0,0)};
        vecs[5] = '{0,1,0,0,0, 2'd1, mk(2,25,0)};  // 0 wraps to 25
        vecs[6] = '{1,0,0,1,0, 2'd0, mk(2,25,0)};  // back beats up
        vecs[7] = '{0,0,1,0,0, 2'd1, mk(2,25,0)};
        vecs[8] = '{1,0,1,0,0, 2'd2, mk(2,25,0)};  // confirm beats up

        bus.game_over = 0; bus.final_score = 0; bus.min_score = 0;
        btns(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Qualifying entry: 250 > 100
        start(250, 100);
        chk("A_q_busy", 32'(bus.busy), 1);
        chk("A_q_done", 32'(bus.done), 0);
        chk("A_q_key",  32'(bus.key_insert), 250);
        step();
        for (int i = 0; i < 9; i++) begin
            btns(vecs[i].up, vecs[i].down, vecs[i].confirm, vecs[i].back);
            bus.game_over = vecs[i].gover;
            if (vecs[i].gover) bus.final_score = 16'd999;
            step();
            bus.game_over = 1'b0;
            chk($sformatf("vec%0d_cursor", i), 32'(bus.cursor), 32'(vecs[i].exp_cur));
            chk($sformatf("vec%0d_str", i), 32'(bus.string_insert), 32'(vecs[i].exp_str));
            chk($sformatf("vec%0d_key", i), 32'(bus.key_insert), 250);
            chk($sformatf("vec%0d_ins", i), 32'(bus.insert), 0);
        end
        btns(0, 0, 1, 0);
        step();
        btns(0, 0, 0, 0);
        chk("A_insert",   32'(bus.insert), 1);
        chk("A_ins_key",  32'(bus.key_insert), 250);
        chk("A_ins_str",  32'(bus.string_insert), 32'(mk(2,25,0)));
        chk("A_ins_done", 32'(bus.done), 0);
        for (int k = 1; k < SETTLE; k++) begin
            step();
            chk("A_settle_ins",  32'(bus.insert), 0);
            chk("A_settle_done", 32'(bus.done), 0);
        end
        step();
        chk("A_done", 32'(bus.done), 1);
        chk("A_qual", 32'(bus.qualified), 1);
        chk("A_done_busy", 32'(bus.busy), 1);
        step();
        chk("A_idle_busy", 32'(bus.busy), 0);
        chk("A_idle_done", 32'(bus.done), 0);
        chk("A_hold_str",  32'(bus.string_insert), 32'(mk(2,25,0)));
        chk("A_ins_count", 32'(ins_cnt), 1);
        chk("A_done_count", 32'(done_cnt), 1);

        // Tie does not qualify
        start(300, 300);
        chk("B_done", 32'(bus.done), 1);
        chk("B_qual", 32'(bus.qualified), 0);
        chk("B_busy", 32'(bus.busy), 1);
        step();
        chk("B_idle", 32'(bus.busy), 0);
        chk("B_ins_count", 32'(ins_cnt), 1);

        // One above min qualifies; then reset during ENTRY
        start(301, 300);
        chk("C_q_done", 32'(bus.done), 0);
        step();
        chk("C_entry_busy", 32'(bus.busy), 1);
        btns(1, 0, 0, 0);
        step();
        btns(0, 0, 0, 0);
        chk("C_str", 32'(bus.string_insert), 32'(mk(1,0,0)));
        #3 rst = 1'b1;
        #1 chk_reset_vals("C_rst");
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) step();
        chk("C_ins_count",  32'(ins_cnt), 1);
        chk("C_done_count", 32'(done_cnt), 2);

        // Reset during SETTLE
        start(500, 0);
        step();
        btns(0, 0, 1, 0);
        repeat (3) step();
        btns(0, 0, 0, 0);
        chk("D_insert", 32'(bus.insert), 1);
        step();
        chk("D_settle_busy", 32'(bus.busy), 1);
        #3 rst = 1'b1;
        #1 chk_reset_vals("D_rst");
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) step();
        chk("D_ins_count",  32'(ins_cnt), 2);
        chk("D_done_count", 32'(done_cnt), 2);

        // Idle in ENTRY at cursor 1
        start(400, 0);
        step();
        btns(0, 0, 1, 0);
        step();
        btns(0, 0, 0, 0);
        chk("E_cursor", 32'(bus.cursor), 1);
`ifdef ENTRY_TIMEOUT_EN
        begin
            bit seen = 0;
            for (int k = 0; k < 40 && !seen; k++) begin
                step();
                if (bus.insert) seen = 1;
            end
            chk("E_timeout_insert", 32'(seen), 1);
            chk("E_timeout_key", 32'(bus.key_insert), 400);
            chk("E_timeout_str", 32'(bus.string_insert), 32'(mk(0,0,0)));
        end
`else
        repeat (1000) step();
        chk("E_no_timeout_ins", 32'(ins_cnt), 2);
        chk("E_still_busy", 32'(bus.busy), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_entry_ctrl.md
# scoreboard_entry_ctrl

High-score entry controller that sequences writes into the self-sorting scoreboard. When a game ends, it latches the final score and compares it with the scoreboard's lowest displayed entry. If the score qualifies, it runs a three-letter name-entry dialogue driven by debounced buttons, then issues a single-cycle insert with the packed name and waits for the sorting network to settle. It sits between the game FSM / button conditioner and the scoreboard's insert port, and is the only writer of that port.

## Interface
Parameters:
- LETTER_W, 5, width of one name letter code
- KEY_W, 16, score width
- LETTER_MAX, 25, highest letter code (0..25 = A..Z)
- SETTLE_CYCLES, 2, cycles held after insert before done
- TIMEOUT_CYCLES, 100_000_000, idle cycles in ENTRY before auto-commit (used only with the macro)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- game_over  in  1  one-cycle pulse; final_score valid in the same cycle
- final_score  in  KEY_W  score to be entered
- min_score  in  KEY_W  scoreboard's lowest displayed entry (score_4)
- btn_up, btn_down, btn_confirm, btn_back  in  1 each  one-cycle debounced pulses
- insert  out  1  one-cycle insert strobe to the scoreboard
- key_insert  out  KEY_W  latched score
- string_insert  out  3*LETTER_W  name; letter 0 in [3*LETTER_W-1 -: LETTER_W], letter 2 in LSBs
- cursor  out  2  active letter index 0..2
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of sequence
- qualified  out  1  valid with done: 1 = inserted, 0 = rejected

## Operation
- States: IDLE, QUALIFY, ENTRY, COMMIT, SETTLE.
- IDLE: on game_over, latch final_score into key_insert, clear all letters to 0 and cursor to 0, then go to QUALIFY. game_over is ignored in every other state.
- QUALIFY: if key_insert > min_score (strict; ties do not qualify), go to ENTRY. Otherwise pulse done with qualified=0 and return to IDLE.
- ENTRY: button priority is confirm > back > up > down. Only the highest-priority asserted button acts in a given cycle.
  - up: letter[cursor] increments; LETTER_MAX wraps to 0.
  - down: letter[cursor] decrements; 0 wraps to LETTER_MAX.
  - confirm: cursor increments; confirm at cursor 2 goes to COMMIT.
  - back: cursor decrements; back at cursor 0 is ignored.
- COMMIT: insert=1 for exactly one cycle, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles. On the last one, pulse done with qualified=1 and return to IDLE.
- key_insert and string_insert stay stable from COMMIT through to the next game_over.
- Reset mid-operation: return to IDLE immediately; insert, done and busy deassert with no partial insert.

## Timing
- Reset values: insert=0, done=0, qualified=0, busy=0, cursor=0, key_insert=0, string_insert=0; state is IDLE.
- game_over is sampled at edge N. QUALIFY is active during cycle N+1. ENTRY starts at N+2, or done pulses in cycle N+1 for a rejected score.
- Button effects are registered: the letter/cursor update is visible the cycle after the pulse.
- Final confirm at edge M: insert is high during cycle M+1, and done is high during cycle M+1+SETTLE_CYCLES.
- min_score is sampled only in QUALIFY.

## Configuration
- ENTRY_TIMEOUT_EN defined: a counter runs in ENTRY and resets on any button pulse. After TIMEOUT_CYCLES cycles with no button, the block goes to COMMIT with the current letters, regardless of cursor position.
- ENTRY_TIMEOUT_EN undefined: no counter is built, and ENTRY waits indefinitely.

## Test plan
- min_score=100, game_over with final_score=250, then up×2, confirm, down×1, confirm, confirm -> insert pulses once with key_insert=250, string_insert={5'd2,5'd25,5'd0}, done with qualified=1 exactly SETTLE_CYCLES later.
- min_score=300, final_score=300 -> done with qualified=0 at N+1, insert never asserts.
- In ENTRY: back at cursor 0 -> cursor stays 0. Same-cycle up+confirm -> cursor advances, letter unchanged.
- game_over pulsed during ENTRY with a different score -> ignored, key_insert unchanged.
- rst asserted during SETTLE and during ENTRY -> outputs return to reset values immediately, no further insert or done.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16, no buttons for 16 cycles at cursor 1 -> insert pulses with the current letters. Without the macro, no insert after 1000 idle cycles.
